// File: rtl/tdp_ram.sv
// tdp_ram: single-clock true dual-port RAM with byte enables, a clear engine and same-address arbitration.
// Latency: read data/valid 1 cycle after the accepted request (2 with OUT_REG=1); collision 1 cycle after.
// Backpressure: none; both ports accept one access per cycle once init_busy is low, requests are dropped while busy.
module tdp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    init_busy,
  output logic                    collision,
  input  logic                    en_a,
  input  logic                    en_b,
  input  logic                    wr_a,
  input  logic                    wr_b,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]   dat_in_a,
  input  logic [DATA_WIDTH-1:0]   dat_in_b,
  output logic [DATA_WIDTH-1:0]   dat_out_a,
  output logic [DATA_WIDTH-1:0]   dat_out_b,
  output logic                    valid_a,
  output logic                    valid_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clear_wr;
  logic                    acc_a, acc_b;
  logic                    same_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_rd_a, mem_rd_b;
  logic [DATA_WIDTH-1:0]   new_a, new_b;
  logic [DATA_WIDTH-1:0]   d1_a, d1_b;
  logic                    v1_a, v1_b;
  logic                    col_q;

  // The clear write for address 0 happens on the first cycle with reset released,
  // so busy lasts exactly DEPTH cycles from release.
  assign clear_wr  = reset && (state != ST_READY);
  assign init_busy = (state != ST_READY);
  assign acc_a     = reset && (state == ST_READY) && en_a;
  assign acc_b     = reset && (state == ST_READY) && en_b;
  assign same_addr = (address_a == address_b);
  assign mem_rd_a  = mem[address_a];
  assign mem_rd_b  = mem[address_b];
  assign collision = col_q;

  // Post-write word at each port's address; port A owns any byte it enables on a shared address.
  always_comb begin
    new_a = mem_rd_a;
    new_b = mem_rd_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && be_a[i])
        new_a[8*i +: 8] = dat_in_a[8*i +: 8];
      else if (same_addr && acc_b && wr_b && be_b[i])
        new_a[8*i +: 8] = dat_in_b[8*i +: 8];
      if (same_addr && acc_a && wr_a && be_a[i])
        new_b[8*i +: 8] = dat_in_a[8*i +: 8];
      else if (wr_b && be_b[i])
        new_b[8*i +: 8] = dat_in_b[8*i +: 8];
    end
  end

  // Control FSM: hold in reset, sweep the clear counter once, then serve accesses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_RESET, ST_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          state   <= (&clr_cnt) ? ST_READY : ST_CLEAR;
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Array writes; on a shared address both ports store the same arbitrated word.
  always_ff @(posedge clk) begin
    if (clear_wr)
      mem[clr_cnt] <= CLEAR_VALUE;
    if (acc_a && wr_a)
      mem[address_a] <= new_a;
    if (acc_b && wr_b)
      mem[address_b] <= new_b;
  end

  // First output stage: read data holds when idle; a reader colliding with a writer sees the old word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d1_a  <= '0;
      d1_b  <= '0;
      v1_a  <= 1'b0;
      v1_b  <= 1'b0;
      col_q <= 1'b0;
    end else begin
      v1_a  <= acc_a;
      v1_b  <= acc_b;
      col_q <= acc_a && acc_b && same_addr && (wr_a || wr_b);
      if (acc_a)
        d1_a <= (wr_a && (RDW_MODE != 0)) ? new_a : mem_rd_a;
      if (acc_b)
        d1_b <= (wr_b && (RDW_MODE != 0)) ? new_b : mem_rd_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] d2_a, d2_b;
      logic                  v2_a, v2_b;
      // Optional second stage; reset flushes anything still in flight.
      always_ff @(posedge clk) begin
        if (!reset) begin
          d2_a <= '0;
          d2_b <= '0;
          v2_a <= 1'b0;
          v2_b <= 1'b0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a)
            d2_a <= d1_a;
          if (v1_b)
            d2_b <= d1_b;
        end
      end
      assign dat_out_a = d2_a;
      assign dat_out_b = d2_b;
      assign valid_a   = v2_a;
      assign valid_b   = v2_b;
    end else begin : g_no_out_reg
      assign dat_out_a = d1_a;
      assign dat_out_b = d1_b;
      assign valid_a   = v1_a;
      assign valid_b   = v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_tdp_ram.sv
// tb_tdp_ram: directed and randomized checks of tdp_ram.
// Latency: follows the OUT_REG setting below (LAT cycles).
// Backpressure: not applicable; stimulus changes on falling edges, outputs sampled on falling edges.
module tb_tdp_ram;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NB = DW / 8;
  localparam int RDW = 1;
  localparam int OREG = 1;
  localparam int LAT = (OREG != 0) ? 2 : 1;
  localparam logic [DW-1:0] CV = 16'hA5A5;
  localparam int NRAND = 10000;

  logic          clk;
  logic          reset;
  logic          init_busy, collision;
  logic          en_a, en_b, wr_a, wr_b;
  logic [NB-1:0] be_a, be_b;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] dat_in_a, dat_in_b;
  logic [DW-1:0] dat_out_a, dat_out_b;
  logic          valid_a, valid_b;

  int tests = 0;
  int fails = 0;

  tdp_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(RDW), .OUT_REG(OREG), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy), .collision(collision),
    .en_a(en_a), .en_b(en_b), .wr_a(wr_a), .wr_b(wr_b), .be_a(be_a), .be_b(be_b),
    .address_a(address_a), .address_b(address_b), .dat_in_a(dat_in_a), .dat_in_b(dat_in_b),
    .dat_out_a(dat_out_a), .dat_out_b(dat_out_b), .valid_a(valid_a), .valid_b(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    en_a = 0; en_b = 0; wr_a = 0; wr_b = 0; be_a = '0; be_b = '0;
    address_a = '0; address_b = '0; dat_in_a = '0; dat_in_b = '0;
  endtask

  // Present one request pair for a single clock, return at the next falling edge.
  task automatic drive(input logic ea, input logic wa, input logic [NB-1:0] ba,
                       input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic wb, input logic [NB-1:0] bb,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db);
    en_a = ea; wr_a = wa; be_a = ba; address_a = aa; dat_in_a = da;
    en_b = eb; wr_b = wb; be_b = bb; address_b = ab; dat_in_b = db;
    @(negedge clk);
    en_a = 0; en_b = 0; wr_a = 0; wr_b = 0;
  endtask

  task automatic wait_lat();
    repeat (LAT - 1) @(negedge clk);
  endtask

  // Release reset and count busy cycles while hammering both ports with writes that must be ignored.
  task automatic run_clear(output int cnt, output int badv);
    cnt = 0; badv = 0;
    reset = 1;
    en_a = 1; wr_a = 1; be_a = '1; address_a = 10'h3FF; dat_in_a = 16'hDEAD;
    en_b = 1; wr_b = 1; be_b = '1; address_b = 10'h1FF; dat_in_b = 16'hBEEF;
    while (init_busy === 1'b1 && cnt < 1100) begin
      cnt++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0) badv++;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", init_busy); end
    tests++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b%b want 00", valid_a, valid_b); end
    tests++; if (dat_out_a !== '0 || dat_out_b !== '0) begin fails++; $display("FAIL reset_dat: got %h %h want 0000 0000", dat_out_a, dat_out_b); end
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL reset_collision: got %b want 0", collision); end
  endtask

  task automatic test_clear();
    int cnt, badv;
    run_clear(cnt, badv);
    tests++; if (cnt != 1024) begin fails++; $display("FAIL clear_cycles: got %0d want 1024", cnt); end
    tests++; if (badv != 0) begin fails++; $display("FAIL clear_valid: got %0d valid cycles want 0", badv); end
    drive(1, 0, '0, 10'h000, '0, 1, 0, '0, 10'h1FF, '0);
    wait_lat();
    tests++; if (dat_out_a !== CV || valid_a !== 1'b1) begin fails++; $display("FAIL clear_rd0: got %h v%b want %h v1", dat_out_a, valid_a, CV); end
    tests++; if (dat_out_b !== CV || valid_b !== 1'b1) begin fails++; $display("FAIL clear_rd511: got %h v%b want %h v1", dat_out_b, valid_b, CV); end
    drive(1, 0, '0, 10'h3FF, '0, 0, 0, '0, '0, '0);
    wait_lat();
    tests++; if (dat_out_a !== CV) begin fails++; $display("FAIL clear_rd1023: got %h want %h", dat_out_a, CV); end
  endtask

  task automatic test_byte_write();
    logic exp_v;
    logic [DW-1:0] exp_d;
    exp_v = (LAT == 1);
    exp_d = (RDW != 0) ? 16'hA534 : 16'hA5A5;
    drive(1, 1, 2'b01, 10'h010, 16'h1234, 0, 0, '0, '0, '0);
    tests++; if (valid_a !== exp_v) begin fails++; $display("FAIL bw_valid_early: got %b want %b", valid_a, exp_v); end
    wait_lat();
    tests++; if (valid_a !== 1'b1 || dat_out_a !== exp_d) begin fails++; $display("FAIL bw_wr_ret: got %h v%b want %h v1", dat_out_a, valid_a, exp_d); end
    @(negedge clk);
    tests++; if (valid_a !== 1'b0 || dat_out_a !== exp_d) begin fails++; $display("FAIL bw_hold: got %h v%b want %h v0", dat_out_a, valid_a, exp_d); end
    drive(1, 0, '0, 10'h010, '0, 1, 0, '0, 10'h010, '0);
    wait_lat();
    tests++; if (dat_out_a !== 16'hA534 || dat_out_b !== 16'hA534) begin fails++; $display("FAIL bw_read: got %h %h want a534 a534", dat_out_a, dat_out_b); end
  endtask

  task automatic test_collision_ww();
    drive(1, 1, 2'b11, 10'h020, 16'h1111, 1, 1, 2'b11, 10'h020, 16'h2222);
    tests++; if (collision !== 1'b1) begin fails++; $display("FAIL ww_col: got %b want 1", collision); end
    wait_lat();
    tests++; if (valid_a !== 1'b1 || valid_b !== 1'b1) begin fails++; $display("FAIL ww_valid: got %b%b want 11", valid_a, valid_b); end
    @(negedge clk);
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL ww_col_pulse: got %b want 0", collision); end
    drive(1, 0, '0, 10'h020, '0, 0, 0, '0, '0, '0);
    wait_lat();
    tests++; if (dat_out_a !== 16'h1111) begin fails++; $display("FAIL ww_full: got %h want 1111", dat_out_a); end
    drive(1, 1, 2'b10, 10'h020, 16'h1111, 1, 1, 2'b11, 10'h020, 16'h2222);
    tests++; if (collision !== 1'b1) begin fails++; $display("FAIL ww_col2: got %b want 1", collision); end
    drive(0, 0, '0, '0, '0, 1, 0, '0, 10'h020, '0);
    wait_lat();
    tests++; if (dat_out_b !== 16'h1122) begin fails++; $display("FAIL ww_split: got %h want 1122", dat_out_b); end
  endtask

  task automatic test_collision_wr();
    logic exp_v;
    logic [DW-1:0] exp_a;
    exp_v = (LAT == 1);
    exp_a = (RDW != 0) ? 16'hBEEF : 16'hA5A5;
    drive(1, 1, 2'b11, 10'h030, 16'hBEEF, 1, 0, '0, 10'h030, '0);
    tests++; if (collision !== 1'b1 || valid_b !== exp_v) begin fails++; $display("FAIL wr_col: got col%b v%b want col1 v%b", collision, valid_b, exp_v); end
    wait_lat();
    tests++; if (dat_out_b !== 16'hA5A5) begin fails++; $display("FAIL wr_reader_old: got %h want a5a5", dat_out_b); end
    tests++; if (dat_out_a !== exp_a) begin fails++; $display("FAIL wr_writer_ret: got %h want %h", dat_out_a, exp_a); end
    drive(1, 0, '0, 10'h030, '0, 1, 0, '0, 10'h030, '0);
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL rr_no_col: got %b want 0", collision); end
    wait_lat();
    tests++; if (dat_out_a !== 16'hBEEF || dat_out_b !== 16'hBEEF) begin fails++; $display("FAIL rr_read: got %h %h want beef beef", dat_out_a, dat_out_b); end
  endtask

  task automatic test_abort();
    int cnt, badv;
    drive(1, 1, 2'b11, 10'h3FF, 16'h1357, 0, 0, '0, '0, '0);
    drive(1, 0, '0, 10'h3FF, '0, 1, 0, '0, 10'h3FF, '0);
    reset = 0;
    @(negedge clk);
    tests++; if (valid_a !== 1'b0 || valid_b !== 1'b0 || dat_out_a !== '0 || dat_out_b !== '0) begin
      fails++; $display("FAIL abort_flush: got %h %h v%b%b want 0 0 v00", dat_out_a, dat_out_b, valid_a, valid_b); end
    reset = 1;
    repeat (300) @(negedge clk);
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL abort_midclear_busy: got %b want 1", init_busy); end
    reset = 0;
    @(negedge clk);
    tests++; if (init_busy !== 1'b1 || valid_a !== 1'b0 || collision !== 1'b0 || dat_out_a !== '0) begin
      fails++; $display("FAIL abort_reset: busy%b v%b col%b dat %h want busy1 v0 col0 dat 0000", init_busy, valid_a, collision, dat_out_a); end
    run_clear(cnt, badv);
    tests++; if (cnt != 1024) begin fails++; $display("FAIL abort_restart_cycles: got %0d want 1024", cnt); end
    drive(1, 0, '0, 10'h3FF, '0, 0, 0, '0, '0, '0);
    wait_lat();
    tests++; if (dat_out_a !== CV) begin fails++; $display("FAIL abort_recleared: got %h want %h", dat_out_a, CV); end
  endtask

  // Random traffic on eight addresses against a byte-level reference model.
  logic [DW-1:0] mm [8];
  logic          ev_a [NRAND];
  logic          ev_b [NRAND];
  logic          hv_a [NRAND];
  logic          hv_b [NRAND];
  logic [DW-1:0] ed_a [NRAND];
  logic [DW-1:0] ed_b [NRAND];
  logic          ec   [NRAND];

  task automatic test_random();
    logic          ea, eb, wa, wb, same, seen_a, seen_b;
    logic [NB-1:0] ba, bb;
    logic [2:0]    aa, ab;
    logic [DW-1:0] da, db, old_a, old_b, nw_a, nw_b, hold_a, hold_b;
    int            nbad;
    nbad = 0;
    seen_a = 0; seen_b = 0; hold_a = '0; hold_b = '0;
    for (int k = 0; k < 8; k++) mm[k] = CV;
    for (int i = 0; i < NRAND + LAT; i++) begin
      if (i >= LAT) begin
        tests++;
        if (valid_a !== ev_a[i-LAT] || valid_b !== ev_b[i-LAT] ||
            (hv_a[i-LAT] && dat_out_a !== ed_a[i-LAT]) || (hv_b[i-LAT] && dat_out_b !== ed_b[i-LAT])) begin
          fails++; nbad++;
          if (nbad <= 5) $display("FAIL rand_out @%0d: got %h v%b / %h v%b want %h v%b / %h v%b", i - LAT,
            dat_out_a, valid_a, dat_out_b, valid_b, ed_a[i-LAT], ev_a[i-LAT], ed_b[i-LAT], ev_b[i-LAT]);
        end
      end
      if (i >= 1 && i - 1 < NRAND) begin
        tests++;
        if (collision !== ec[i-1]) begin
          fails++; nbad++;
          if (nbad <= 5) $display("FAIL rand_col @%0d: got %b want %b", i - 1, collision, ec[i-1]);
        end
      end
      if (i < NRAND) begin
        ea = ($urandom_range(0, 3) != 0); eb = ($urandom_range(0, 3) != 0);
        wa = 1'($urandom_range(0, 1));    wb = 1'($urandom_range(0, 1));
        ba = NB'($urandom_range(0, 3));   bb = NB'($urandom_range(0, 3));
        aa = 3'($urandom_range(0, 7));    ab = 3'($urandom_range(0, 7));
        da = DW'($urandom);               db = DW'($urandom);
        same = ea && eb && (aa == ab);
        old_a = mm[aa]; old_b = mm[ab];
        nw_a = old_a; nw_b = old_b;
        for (int k = 0; k < NB; k++) begin
          if (ba[k]) nw_a[8*k +: 8] = da[8*k +: 8];
          else if (same && wb && bb[k]) nw_a[8*k +: 8] = db[8*k +: 8];
          if (same && wa && ba[k]) nw_b[8*k +: 8] = da[8*k +: 8];
          else if (bb[k]) nw_b[8*k +: 8] = db[8*k +: 8];
        end
        if (ea && wa) mm[aa] = nw_a;
        if (eb && wb) mm[ab] = nw_b;
        if (ea) begin hold_a = (wa && RDW != 0) ? nw_a : old_a; seen_a = 1; end
        if (eb) begin hold_b = (wb && RDW != 0) ? nw_b : old_b; seen_b = 1; end
        ev_a[i] = ea; ev_b[i] = eb; hv_a[i] = seen_a; hv_b[i] = seen_b;
        ed_a[i] = hold_a; ed_b[i] = hold_b;
        ec[i] = same && (wa || wb);
        en_a = ea; wr_a = wa; be_a = ba; address_a = {7'd0, aa}; dat_in_a = da;
        en_b = eb; wr_b = wb; be_b = bb; address_b = {7'd0, ab}; dat_in_b = db;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_clear();
    test_byte_write();
    test_collision_ww();
    test_collision_wr();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
